// File: rtl/mem_arbiter.sv
// Arbitrates one memory controller between the instruction-fetch and load/store ports.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants when both ports request (default: LS priority).
module mem_arbiter #(
    parameter logic [2:0] IF_WORK_TYPE = 3'b010
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_is_write,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data_in,
    input  logic [2:0]  ls_work_type,
    output logic        ls_ready,
    output logic [31:0] ls_data,
    output logic        mc_new_task,
    output logic        mc_is_write,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_data_in,
    output logic [2:0]  mc_work_type,
    input  logic [31:0] mc_data_out,
    input  logic        mc_ready,
    input  logic        mc_busy
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

    state_e state_q, state_d;
    logic   wr_q, wr_d;
    logic   issue, grant_ls;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic   prefer_if_q, prefer_if_d;  // set when LS was the last port granted
`endif

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_ls = ls_req && !(if_req && prefer_if_q);
`else
        grant_ls = ls_req;
`endif
        issue = !rst_in && rdy_in && !rob_clear && (state_q == IDLE) && (ls_req || if_req);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prefer_if_q <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q     <= state_d;
            wr_q        <= wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prefer_if_q <= prefer_if_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prefer_if_d = prefer_if_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d     = grant_ls ? BUSY_LS : BUSY_IF;
                    wr_d        = grant_ls && ls_is_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    prefer_if_d = grant_ls;
`endif
                end
            end
            BUSY_IF: if (rob_clear || mc_ready) state_d = IDLE;
            // A store already handed to the controller cannot be recalled, so a flush is ignored.
            BUSY_LS: if (wr_q ? !mc_busy : (rob_clear || mc_ready)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mc_new_task  = 1'b0;
        mc_is_write  = 1'b0;
        mc_addr      = '0;
        mc_data_in   = '0;
        mc_work_type = '0;
        if_ready     = 1'b0;
        if_data      = '0;
        ls_ready     = 1'b0;
        ls_data      = '0;
        if (!rst_in && rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        mc_new_task = 1'b1;
                        if (grant_ls) begin
                            mc_is_write  = ls_is_write;
                            mc_addr      = ls_addr;
                            mc_data_in   = ls_data_in;
                            mc_work_type = ls_work_type;
                        end else begin
                            mc_addr      = if_addr;
                            mc_work_type = IF_WORK_TYPE;
                        end
                    end
                end
                BUSY_IF: begin
                    if (!rob_clear && mc_ready) begin
                        if_ready = 1'b1;
                        if_data  = mc_data_out;
                    end
                end
                BUSY_LS: begin
                    if (wr_q) begin
                        ls_ready = !mc_busy;
                    end else if (!rob_clear && mc_ready) begin
                        ls_ready = 1'b1;
                        ls_data  = mc_data_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IF_WORK_TYPE, default 3'b010, work_type driven for instruction fetches (signed word).
REQ-002 SHALL have ports: clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have ports: rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: rdy_in  input  1  global enable; when low, all state holds and mc_new_task is 0.
REQ-005 SHALL have ports: rob_clear  input  1  pipeline flush.
REQ-006 SHALL have ports: if_req  input  1; if_addr  input  32; if_ready  output  1; if_data  output  32 (instruction-fetch requester).
REQ-007 SHALL have ports: ls_req  input  1; ls_is_write  input  1; ls_addr  input  32; ls_data_in  input  32; ls_work_type  input  3; ls_ready  output  1; ls_data  output  32 (load/store requester).
REQ-008 SHALL have ports: mc_new_task, mc_is_write  output  1; mc_addr, mc_data_in  output  32; mc_work_type  output  3; mc_data_out  input  32; mc_ready  input  1 (read data valid); mc_busy  input  1 (controller is_working).

Function
REQ-009 SHALL implement states IDLE, BUSY_IF, BUSY_LS.
REQ-010 Requesters SHALL hold req and fields stable until their ready pulse or rob_clear; arbiter SHALL not register request fields.
REQ-011 In IDLE with rdy_in=1, rob_clear=0 and any request, SHALL assert mc_new_task for exactly that cycle (combinational) with winner's fields, and enter BUSY_<winner> next edge.
REQ-012 Fetch issue SHALL drive mc_is_write=0, mc_work_type=IF_WORK_TYPE, mc_data_in=0.
REQ-013 mc_new_task SHALL be 0 in any BUSY state; no back-to-back issue in the completion cycle (one IDLE cycle minimum between tasks).
REQ-014 In BUSY_x for a read, completion SHALL be mc_ready=1: x_ready=1 that cycle, x_data=mc_data_out, state->IDLE.
REQ-015 In BUSY_LS for a write, completion SHALL be mc_busy=0: ls_ready=1 that cycle (ack, ls_data=0), state->IDLE.
REQ-016 Byte-access latency: issue T, ready at T+1; word read: ready at T+4.
REQ-017 if_ready and ls_ready SHALL never be high in the same cycle, and SHALL be 0 outside completion cycles.
REQ-018 rob_clear=1 in BUSY_IF, or BUSY_LS with a read, SHALL force IDLE next edge with no ready pulse.
REQ-019 rob_clear=1 in BUSY_LS with a write SHALL not affect it; write completes and acks normally.
REQ-020 rob_clear=1 in IDLE SHALL suppress issue that cycle.
REQ-021 Arbiter SHALL latch the write flag of the current task at issue for REQ-015/018/019 decisions.

Reset
REQ-022 rst_in=1 SHALL force IDLE, priority pointer to "LS first", all outputs 0, regardless of rdy_in; an in-flight task is abandoned.
REQ-023 First issue after reset SHALL occur in the first cycle with rst_in=0 and a request.

Configuration
REQ-024 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both request in IDLE, winner SHALL be the port not granted last (pointer updated at each issue).
REQ-025 Macro undefined: ls_req SHALL always win over if_req (fixed priority); no pointer state.

Verification
REQ-026 Only if_req, addr 0x100, memory word 0x11223344 -> mc_new_task one cycle, if_ready at T+4, if_data=0x11223344.
REQ-027 ls_req+if_req together in IDLE, LS lb at 0x20 (byte 0x80) -> LS served first, ls_data=0xFFFFFF80 at T+1; fetch issued after one IDLE cycle.
REQ-028 LS sw 0xDEADBEEF to 0x40, rob_clear at T+2 -> write continues, ls_ready pulse at mc_busy fall, memory 0x40..0x43 = EF BE AD DE.
REQ-029 Fetch in flight, rob_clear at T+2 -> no if_ready, IDLE at T+3, new fetch issued T+3.
REQ-030 MEM_ARB_ROUND_ROBIN_EN defined, both ports requesting continuously -> grants alternate LS, IF, LS, IF; undefined -> LS every time until ls_req drops.
REQ-031 rst_in asserted mid word read -> all outputs 0 next cycle, state IDLE, no ready pulse.
